// File: rtl/tmds_align_ctrl_pkg.sv
// Shared TMDS definitions: control-token codes, alignment states, token matcher.
package tmds_pkg;

  localparam int unsigned TMDS_W = 10;

  localparam logic [TMDS_W-1:0] CTL_TOK_00 = 10'b1101010100;
  localparam logic [TMDS_W-1:0] CTL_TOK_01 = 10'b0010101011;
  localparam logic [TMDS_W-1:0] CTL_TOK_10 = 10'b0101010100;
  localparam logic [TMDS_W-1:0] CTL_TOK_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SLIP   = 2'd1,
    SETTLE = 2'd2,
    LOCKED = 2'd3
  } align_state_e;

  typedef struct packed {
    logic       hit;
    logic [1:0] c;
  } ctl_match_t;

  // Classify a raw word as one of the four control tokens, returning {hit, C1C0}.
  function automatic ctl_match_t tmds_is_ctl(input logic [TMDS_W-1:0] word);
    ctl_match_t m;
    m.hit = 1'b0;
    m.c   = 2'b00;
    case (word)
      CTL_TOK_00: begin m.hit = 1'b1; m.c = 2'b00; end
      CTL_TOK_01: begin m.hit = 1'b1; m.c = 2'b01; end
      CTL_TOK_10: begin m.hit = 1'b1; m.c = 2'b10; end
      CTL_TOK_11: begin m.hit = 1'b1; m.c = 2'b11; end
      default:    begin m.hit = 1'b0; m.c = 2'b00; end
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tmds_align_ctrl_if.sv
// Deserializer-side word stream and aligner status/outputs for one TMDS channel.
interface tmds_align_ctrl_if;
  logic [9:0] din;
  logic       bitslip;
  logic       locked;
  logic       de;
  logic [1:0] ctl;
  logic [9:0] dout;
  logic [3:0] slip_count;

  // Stream source / status consumer (deserializer + decoder side)
  modport master (
    output din,
    input  bitslip, locked, de, ctl, dout, slip_count
  );

  // Aligner side
  modport slave (
    input  din,
    output bitslip, locked, de, ctl, dout, slip_count
  );
endinterface

// File: rtl/tmds_align_ctrl_ctl_detect.sv
// Control-token matcher plus saturating run counter; flags the cycle a run first reaches CTL_RUN.
module tmds_ctl_detect
  import tmds_pkg::*;
#(
  parameter int unsigned CTL_RUN = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  din,
  input  logic        hold,
  input  logic        clr,
  output logic        tok_hit_c,
  output logic [1:0]  tok_ctl_c,
  output logic        qual_c
);

  localparam int unsigned RUN_W = $clog2(CTL_RUN + 1);

  ctl_match_t       match_c;
  logic [RUN_W-1:0] run_cnt;

  assign match_c   = tmds_is_ctl(din);
  assign tok_hit_c = match_c.hit;
  assign tok_ctl_c = match_c.c;
  // Only the token that lifts the run onto CTL_RUN qualifies; a saturated run does not.
  assign qual_c    = match_c.hit && !hold && (run_cnt == RUN_W'(CTL_RUN - 1));

  // Run counter: clears on non-token, settle hold or lock drop; saturates at CTL_RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt <= '0;
    end else if (hold || clr || !match_c.hit) begin
      run_cnt <= '0;
    end else if (run_cnt != RUN_W'(CTL_RUN)) begin
      run_cnt <= run_cnt + RUN_W'(1);
    end
  end

endmodule

// File: rtl/tmds_align_ctrl.sv
// TMDS word aligner: hunts for control-token runs, issues bitslips, supervises lock, tags de/ctl.
module tmds_align_ctrl
  import tmds_pkg::*;
#(
  parameter int unsigned SEARCH_WORDS = 1024,
  parameter int unsigned CTL_RUN      = 8,
  parameter int unsigned SLIP_SETTLE  = 16,
  parameter int unsigned LOCK_TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  tmds_align_ctrl_if.slave bus
);

  localparam int unsigned WORD_W   = (SEARCH_WORDS > 1) ? $clog2(SEARCH_WORDS) : 1;
  localparam int unsigned SETTLE_W = (SLIP_SETTLE  > 1) ? $clog2(SLIP_SETTLE)  : 1;
  localparam int unsigned TMO_W    = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  align_state_e        state, state_next;
  logic [WORD_W-1:0]   word_cnt, word_next;
  logic [SETTLE_W-1:0] settle_cnt, settle_next;
  logic [TMO_W-1:0]    tmo_cnt, tmo_next;
  logic                run_clr_c;
  logic                hold_c;

  logic                tok_hit_c;
  logic [1:0]          tok_ctl_c;
  logic                qual_c;

  logic                bitslip_q;
  logic                locked_q;
  logic                de_q;
  logic [1:0]          ctl_q;
  logic [9:0]          dout_q;
  logic [3:0]          slip_count_q;

  assign hold_c = (state == SETTLE);

  tmds_ctl_detect #(
    .CTL_RUN (CTL_RUN)
  ) u_detect (
    .clk       (clk),
    .rst       (rst),
    .din       (bus.din),
    .hold      (hold_c),
    .clr       (run_clr_c),
    .tok_hit_c (tok_hit_c),
    .tok_ctl_c (tok_ctl_c),
    .qual_c    (qual_c)
  );

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SEARCH;
      word_cnt   <= '0;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
    end else begin
      state      <= state_next;
      word_cnt   <= word_next;
      settle_cnt <= settle_next;
      tmo_cnt    <= tmo_next;
    end
  end

  // Next-state and counter update; a qualifying event beats both slip and timeout.
  always_comb begin
    state_next  = state;
    word_next   = word_cnt;
    settle_next = settle_cnt;
    tmo_next    = tmo_cnt;
    run_clr_c   = 1'b0;
    case (state)
      SEARCH: begin
        if (qual_c) begin
          state_next = LOCKED;
          tmo_next   = '0;
          word_next  = '0;
        end else if (word_cnt == WORD_W'(SEARCH_WORDS - 1)) begin
          state_next = SLIP;
          word_next  = '0;
        end else begin
          word_next = word_cnt + WORD_W'(1);
        end
      end
      SLIP: begin
        state_next  = SETTLE;
        settle_next = '0;
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_W'(SLIP_SETTLE - 1)) begin
          state_next  = SEARCH;
          word_next   = '0;
          settle_next = '0;
        end else begin
          settle_next = settle_cnt + SETTLE_W'(1);
        end
      end
      LOCKED: begin
        if (qual_c) begin
          tmo_next = '0;
        end else if (tmo_cnt == TMO_W'(LOCK_TIMEOUT - 1)) begin
          state_next = SEARCH;
          word_next  = '0;
          tmo_next   = '0;
          run_clr_c  = 1'b1;
        end else begin
          tmo_next = tmo_cnt + TMO_W'(1);
        end
      end
      default: begin
        state_next = SEARCH;
        word_next  = '0;
      end
    endcase
  end

  // Registered outputs: bitslip lives exactly for the SLIP cycle; word path is one cycle late.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitslip_q    <= 1'b0;
      locked_q     <= 1'b0;
      de_q         <= 1'b0;
      ctl_q        <= 2'b00;
      dout_q       <= '0;
      slip_count_q <= '0;
    end else begin
      bitslip_q <= (state_next == SLIP);
      if (state_next == SLIP) begin
        slip_count_q <= (slip_count_q == 4'd9) ? 4'd0 : slip_count_q + 4'd1;
      end
      locked_q <= (state == LOCKED);
      de_q     <= (state == LOCKED) && !tok_hit_c;
      if (tok_hit_c) begin
        ctl_q <= tok_ctl_c;
      end
      dout_q <= bus.din;
    end
  end

  assign bus.bitslip    = bitslip_q;
  assign bus.locked     = locked_q;
  assign bus.de         = de_q;
  assign bus.ctl        = ctl_q;
  assign bus.dout       = dout_q;
  assign bus.slip_count = slip_count_q;

endmodule

// File: tb/tb_tmds_align_ctrl.sv
// Directed + randomized bench for tmds_align_ctrl against a phase-arithmetic reference model.
module tb_tmds_align_ctrl;

  localparam int SW = 32;
  localparam int CR = 8;
  localparam int SS = 4;
  localparam int LT = 128;
  localparam int P  = SW + 1 + SS;   // hunt period: search words, slip, settle

  logic clk = 1'b0;
  logic rst;

  tmds_align_ctrl_if bus ();

  tmds_align_ctrl #(
    .SEARCH_WORDS (SW),
    .CTL_RUN      (CR),
    .SLIP_SETTLE  (SS),
    .LOCK_TIMEOUT (LT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [9:0] tok_tab [4];

  // Reference model state
  bit   m_aligned;
  int   m_hunt;      // cycles since the hunt (re)started
  int   m_run;       // unbounded count of consecutive counted tokens
  int   m_quiet;     // words in lock since last qualifying run
  int   m_slips;
  logic m_bitslip, m_locked, m_de;
  int   m_ctl;
  logic [9:0] m_dout;

  // Bench bookkeeping
  int n_cyc = 0;
  int n_pulses = 0;
  int rot = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int tok_index(input logic [9:0] w);
    for (int i = 0; i < 4; i++) if (tok_tab[i] == w) return i;
    return -1;
  endfunction

  function automatic logic [9:0] rnd_data();
    logic [9:0] w;
    w = 10'($urandom_range(0, 1023));
    if (tok_index(w) >= 0) w = w ^ 10'h001;
    return w;
  endfunction

  function automatic logic [9:0] rnd_tok();
    return tok_tab[$urandom_range(0, 3)];
  endfunction

  function automatic logic [9:0] rotl(input logic [9:0] w, input int n);
    logic [9:0] r;
    r = w;
    repeat (n) r = {r[8:0], r[9]};
    return r;
  endfunction

  task automatic m_reset();
    m_aligned = 1'b0; m_hunt = 0; m_run = 0; m_quiet = 0; m_slips = 0;
    m_bitslip = 1'b0; m_locked = 1'b0; m_de = 1'b0; m_ctl = 0; m_dout = '0;
  endtask

  // One clock edge of the reference model, given the word presented on that edge.
  task automatic m_step(input logic [9:0] w);
    int  ti;
    int  phase;
    bit  hit, qual, ignore;
    ti  = tok_index(w);
    hit = (ti >= 0);
    m_dout   = w;
    if (hit) m_ctl = ti;
    m_de     = m_aligned && !hit;
    m_locked = m_aligned;
    phase  = m_hunt % P;
    ignore = !m_aligned && (phase > SW);
    if (ignore || !hit) m_run = 0;
    else m_run++;
    qual = (m_run == CR);
    m_bitslip = 1'b0;
    if (m_aligned) begin
      if (qual) m_quiet = 0;
      else if (m_quiet == LT - 1) begin
        m_aligned = 1'b0; m_hunt = 0; m_run = 0; m_quiet = 0;
      end else m_quiet++;
    end else if (qual && phase < SW) begin
      m_aligned = 1'b1; m_quiet = 0;
    end else begin
      m_hunt++;
      m_bitslip = ((m_hunt % P) == SW);
      if (m_bitslip) m_slips = (m_slips + 1) % 10;
    end
  endtask

  task automatic check_all();
    chk("bitslip",    bus.bitslip,    m_bitslip);
    chk("locked",     bus.locked,     m_locked);
    chk("de",         bus.de,         m_de);
    chk("ctl",        bus.ctl,        m_ctl);
    chk("dout",       bus.dout,       m_dout);
    chk("slip_count", bus.slip_count, m_slips);
  endtask

  // Present a word, clock it, step the model, then sample outputs off the edge.
  task automatic cyc(input logic [9:0] w);
    bus.din = w;
    @(posedge clk);
    m_step(w);
    #1;
    n_cyc++;
    if (bus.bitslip) begin
      n_pulses++;
      if (rot > 0) rot--;
    end
    check_all();
  endtask

  initial begin
    int t0, de_ones, p0, guard;
    tok_tab[0] = 10'b1101010100;
    tok_tab[1] = 10'b0010101011;
    tok_tab[2] = 10'b0101010100;
    tok_tab[3] = 10'b1010101011;

    // Reset state
    rst = 1'b1;
    bus.din = '0;
    m_reset();
    #12;
    check_all();
    rst = 1'b0;

    // Continuous 00 tokens: locked rises on cycle 9, no bitslip
    for (int i = 1; i <= 9; i++) begin
      cyc(tok_tab[0]);
      if (i == 8) chk("lock_c8", bus.locked, 1'b0);
    end
    chk("lock_c9", bus.locked, 1'b1);
    chk("lock_ctl", bus.ctl, 2'b00);
    chk("lock_de", bus.de, 1'b0);
    chk("lock_noslip", n_pulses, 0);

    // 100 data words then 8 tokens 01: de high exactly 100 cycles, lock held
    de_ones = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(10'h1F0);
      if (bus.de) de_ones++;
    end
    chk("data_dout", bus.dout, 10'h1F0);
    for (int i = 0; i < 8; i++) begin
      cyc(tok_tab[1]);
      if (bus.de) de_ones++;
    end
    chk("de_len", de_ones, 100);
    chk("ctl_01", bus.ctl, 2'b01);
    chk("lock_held", bus.locked, 1'b1);

    // 128 random data words: timeout, locked falls the cycle after the 128th word
    for (int i = 0; i < LT; i++) cyc(rnd_data());
    chk("tmo_still", bus.locked, 1'b1);

    // Qualifying run landing on the last search word: lock without slip
    p0 = n_pulses;
    cyc(rnd_data());
    chk("tmo_fall", bus.locked, 1'b0);
    chk("tmo_de", bus.de, 1'b0);
    for (int i = 1; i < 24; i++) cyc(rnd_data());
    for (int i = 0; i < CR; i++) cyc(rnd_tok());
    cyc(rnd_tok());
    chk("edge_lock", bus.locked, 1'b1);
    chk("edge_noslip", n_pulses, p0);

    // Time out again, then 11 forced slips: slip_count wraps to 1
    guard = 0;
    while (bus.locked && guard < 200) begin
      cyc(rnd_data());
      guard++;
    end
    chk("unlock2", bus.locked, 1'b0);
    p0 = n_pulses;
    for (int i = 0; i < 11 * P; i++) cyc(rnd_data());
    chk("slips11", n_pulses - p0, 11);
    chk("slip_wrap", bus.slip_count, 4'd1);

    // Async reset while bitslip is high
    guard = 0;
    while (!bus.bitslip && guard < 40) begin
      cyc(rnd_data());
      guard++;
    end
    chk("slip_seen", bus.bitslip, 1'b1);
    #2;
    rst = 1'b1;
    m_reset();
    #1;
    chk("rst_bitslip", bus.bitslip, 1'b0);
    chk("rst_slipcnt", bus.slip_count, 4'd0);
    chk("rst_dout", bus.dout, 10'd0);
    chk("rst_ctl", bus.ctl, 2'b00);
    check_all();
    @(posedge clk);
    #1;
    chk("rst_hold_bitslip", bus.bitslip, 1'b0);
    #2;
    rst = 1'b0;

    // Stream rotated by 3: slip every P cycles, lock after the 3rd slip
    rot = 3;
    p0 = n_pulses;
    t0 = n_cyc;
    guard = 0;
    while (!bus.locked && guard < 300) begin
      cyc(rotl(rnd_tok(), rot));
      if (bus.bitslip) chk("slip_at", n_cyc - t0, SW + P * (n_pulses - p0 - 1));
      guard++;
    end
    chk("rot_locked", bus.locked, 1'b1);
    chk("rot_pulses", n_pulses - p0, 3);
    chk("rot_slipcnt", bus.slip_count, 4'd3);
    cyc(rnd_data());
    chk("rot_de", bus.de, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
